oh_skidbuf: RTL and testbench
=============================

OH_SKIDBUF -- requirements
Module: oh_skidbuf

Interface
REQ-001 Parameter: DW, default 32, data width in bits, legal range 1 to 1024.
REQ-002 Parameter: PROP, default "DEFAULT", implementation property string passed through to cell selection; has no functional effect.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 nreset  input  1  asynchronous active-low reset; assertion takes effect immediately, deassertion is sampled on clk.
REQ-005 in_valid  input  1  upstream data valid.
REQ-006 in_data  input  DW  upstream data.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 out_valid  output  1  downstream data valid.
REQ-009 out_data  output  DW  downstream data.
REQ-010 out_ready  input  1  downstream can accept a word this cycle.

Function
REQ-011 The block SHALL be a 2-entry elastic (skid) buffer with main and skid registers, preserving word order without loss or duplication.
REQ-012 Push SHALL be in_valid && in_ready at a rising edge; pop SHALL be out_valid && out_ready at a rising edge.
REQ-013 in_ready, out_valid and out_data SHALL be driven directly from flops, with no combinational path from any input.
REQ-014 State machine SHALL have states EMPTY (0 words), ONE (main valid), FULL (main and skid valid).
REQ-015 EMPTY: push -> ONE with main=in_data; otherwise stay.
REQ-016 ONE: push&pop -> ONE with main=in_data; push only -> FULL with skid=in_data; pop only -> EMPTY; neither -> stay.
REQ-017 FULL: pop -> ONE with main=skid; otherwise stay; push cannot occur because in_ready=0.
REQ-018 out_valid SHALL be 1 exactly in states ONE and FULL, and out_data SHALL equal main.
REQ-019 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, except as stated in REQ-024.
REQ-020 Latency SHALL be 1 cycle: a word pushed at edge N is on out_data with out_valid=1 after edge N, when the buffer was EMPTY or a pop occurs at edge N.
REQ-021 Throughput SHALL be 1 word per cycle in steady state when out_ready is held at 1.
REQ-022 While out_valid=1 and out_ready=0, out_data SHALL remain stable until the next pop.
REQ-023 in_data SHALL be ignored when in_valid=0, and out_data SHALL retain its last value in EMPTY.

Reset
REQ-024 While nreset=0: state=EMPTY, out_valid=0, in_ready=0, main=0, skid=0.
REQ-025 in_ready SHALL rise at the first rising clk edge after nreset deasserts, and no push SHALL occur before that edge.
REQ-026 Reset asserted mid-operation SHALL discard all buffered words immediately; no stale word SHALL appear after reset.

Verification
REQ-027 Reset release: nreset 0->1, in_valid=1, in_data=0xA5 held -> in_ready=0 in the first cycle, 1 after the next edge; 0xA5 appears on out_data one cycle after acceptance.
REQ-028 Streaming: out_ready=1, push 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on consecutive cycles, each lagging its push by 1 cycle, in_ready constantly 1.
REQ-029 Backpressure: out_ready=0, push 0x10 then 0x11 -> state FULL, in_ready=0, out_data=0x10 stable; third word 0x12 held on in_data is not accepted.
REQ-030 Drain from FULL: after REQ-029, out_ready=1 for 2 cycles -> out_data 0x10 then 0x11, in_ready=1 after the first pop, out_valid=0 after the second.
REQ-031 Simultaneous push and pop in ONE: main=0x20, push 0x21 with out_ready=1 -> out_data=0x21 next cycle, state ONE, in_ready stays 1.
REQ-032 Mid-operation reset: in FULL, pulse nreset low between clock edges -> out_valid=0 and in_ready=0 immediately; after release, no 0x10/0x11 is ever output.

Source files
------------

// File: rtl/oh_skidbuf.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | oh_skidbuf : 2-entry elastic buffer, every output driven straight from a flop |
// | Revision   : 1.0                                                             |
// +-----------------------------------------------------------------------------+
module oh_skidbuf #(
    parameter int DW   = 32,
    parameter     PROP = "DEFAULT"
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          w_push, w_pop;

    // PROP only steers cell selection in hardened flows; the logic is identical.
    if (PROP != "DEFAULT") begin : g_prop_custom
    end else begin : g_prop_default
    end

    assign w_push = in_valid && in_ready_q;
    assign w_pop  = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (w_push) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (w_push && w_pop) begin
                    main_d = in_data;
                end else if (w_push) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (w_pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (w_pop) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Handshake flags are precomputed from the next state so they leave a flop.
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

endmodule
`default_nettype wire

// File: tb/tb_oh_skidbuf.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_oh_skidbuf : scoreboard bench for oh_skidbuf                              |
// | Revision      : 1.0                                                          |
// +-----------------------------------------------------------------------------+
module tb_oh_skidbuf;

    localparam int DW = 32;

    logic          clk;
    logic          nreset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;

    int            n_checks;
    int            n_errors;
    logic [DW-1:0] sb_q[$];

    oh_skidbuf #(
        .DW  (DW),
        .PROP("DEFAULT")
    ) u_dut (
        .clk      (clk),
        .nreset   (nreset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Handshakes are evaluated just before the edge, with inputs and outputs settled.
    task automatic tick();
        logic          push, pop;
        logic [DW-1:0] exp_word;
        push = in_valid && in_ready;
        pop  = out_valid && out_ready;
        if (pop) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", {32'd0, out_data}, 64'hDEAD);
            end else begin
                exp_word = sb_q.pop_front();
                check("sb_data", {32'd0, out_data}, {32'd0, exp_word});
            end
        end
        if (push) sb_q.push_back(in_data);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        nreset    = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA5;
        out_ready = 1'b0;

        // Reset state and release
        @(posedge clk); #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {32'd0, out_data}, 64'd0);
        nreset = 1'b1;
        check("rel_in_ready_first", {63'd0, in_ready}, 64'd0);
        tick();
        check("rel_in_ready_after", {63'd0, in_ready}, 64'd1);
        check("rel_no_early_push", {63'd0, out_valid}, 64'd0);
        tick();
        in_valid = 1'b0;
        check("rel_out_valid", {63'd0, out_valid}, 64'd1);
        check("rel_out_data", {32'd0, out_data}, 64'hA5);
        out_ready = 1'b1;
        tick();
        check("rel_drained", {63'd0, out_valid}, 64'd0);

        // Streaming at full rate
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = i;
            check("stream_in_ready", {63'd0, in_ready}, 64'd1);
            tick();
            check("stream_out_valid", {63'd0, out_valid}, 64'd1);
            check("stream_out_data", {32'd0, out_data}, i);
        end
        in_valid = 1'b0;
        tick();
        check("stream_empty", {63'd0, out_valid}, 64'd0);

        // Backpressure to FULL, then drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h10; tick();
        in_data   = 32'h11; tick();
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_out_data", {32'd0, out_data}, 64'h10);
        in_data = 32'h12;
        tick(); tick();
        check("bp_stable_data", {32'd0, out_data}, 64'h10);
        check("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("drain_in_ready", {63'd0, in_ready}, 64'd1);
        check("drain_out_data", {32'd0, out_data}, 64'h11);
        tick();
        check("drain_out_valid", {63'd0, out_valid}, 64'd0);

        // Simultaneous push and pop while holding one word
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h20;
        tick();
        in_data   = 32'h21;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("pp_out_data", {32'd0, out_data}, 64'h21);
        check("pp_out_valid", {63'd0, out_valid}, 64'd1);
        check("pp_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        check("pp_empty", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset while FULL discards both words
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h10; tick();
        in_data   = 32'h11; tick();
        in_valid  = 1'b0;
        check("mr_full", {63'd0, in_ready}, 64'd0);
        #2 nreset = 1'b0;
        #1;
        check("mr_out_valid", {63'd0, out_valid}, 64'd0);
        check("mr_in_ready", {63'd0, in_ready}, 64'd0);
        check("mr_out_data", {32'd0, out_data}, 64'd0);
        sb_q.delete();
        #1 nreset = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mr_no_stale", {63'd0, out_valid}, 64'd0);
        end
        check("mr_in_ready_back", {63'd0, in_ready}, 64'd1);

        // Random traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom();
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("final_empty", {63'd0, out_valid}, 64'd0);
        check("sb_leftover", sb_q.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
